// File: rtl/sipo_deserializer.sv
// MSB-first serial-in/parallel-out receiver with a valid/ack holding register and sticky overrun.
// Optional even-parity bit per word when SIPO_PARITY_EN is defined (adds PAR state and parity_err).
module sipo_deserializer #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         sin,
    input  logic         sen,
    input  logic         sync,
    input  logic         q_ack,
    output logic [N-1:0] q,
    output logic         q_valid,
    output logic         overrun
`ifdef SIPO_PARITY_EN
    ,
    output logic         parity_err
`endif
);

    localparam int unsigned   CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

`ifdef SIPO_PARITY_EN
    localparam int unsigned SRW = N;
`else
    // Without parity the word is {sr[N-2:0], sin} at completion, so the
    // shift register MSB is never observed and is not stored.
    localparam int unsigned SRW = N - 1;
`endif

`ifdef SIPO_PARITY_EN
    typedef enum logic {
        ST_DATA,
        ST_PAR
    } state_e;

    state_e state_q, state_d;
    logic   perr_q, perr_d, perr_new;
`endif

    logic [SRW-1:0] sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   q_q, q_d, word;
    logic           valid_q, valid_d;
    logic           ovr_q, ovr_d;
    logic           complete, accept;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
            state_q <= ST_DATA;
            perr_q  <= 1'b0;
`endif
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SIPO_PARITY_EN
            state_q <= state_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        complete = 1'b0;
`ifdef SIPO_PARITY_EN
        state_d  = state_q;
        perr_d   = perr_q;
        word     = sr_q;
        perr_new = ^{sr_q, sin};
`else
        word     = {sr_q, sin};
`endif

        if (sen) begin
            sr_d = SRW'({sr_q, sin});
            // Sync wins over both completion and the parity slot.
            if (sync) begin
                cnt_d = CW'(1);
`ifdef SIPO_PARITY_EN
                state_d = ST_DATA;
            end else if (state_q == ST_PAR) begin
                complete = 1'b1;
                cnt_d    = '0;
                state_d  = ST_DATA;
`endif
            end else if (cnt_q == CNT_LAST) begin
`ifdef SIPO_PARITY_EN
                state_d = ST_PAR;
`else
                complete = 1'b1;
                cnt_d    = '0;
`endif
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        accept = complete && (!valid_q || q_ack);

        if (accept) begin
            q_d     = word;
            valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
            perr_d  = perr_new;
`endif
        end else if (q_ack && valid_q) begin
            valid_d = 1'b0;
`ifdef SIPO_PARITY_EN
            perr_d  = 1'b0;
`endif
        end

        if (complete && !accept) begin
            ovr_d = 1'b1;
        end else if (q_ack && valid_q) begin
            ovr_d = 1'b0;
        end
    end

    assign q       = q_q;
    assign q_valid = valid_q;
    assign overrun = ovr_q;
`ifdef SIPO_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
